// File: rtl/seq_divider_8bit_if.sv
// Operand/result handshake bundle for seq_divider_8bit.
// The slave modport is the divider side; the master modport is the operand source and result sink.
interface seq_divider_8bit_if #(
  parameter int unsigned DW = 8
);
  localparam int unsigned NW = 2 * DW - 1;

  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_zero;
  logic          q_ovf;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, q_ovf
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, q_ovf
  );
endinterface

// File: rtl/seq_divider_8bit.sv
// Sequential restoring divider: a (2*DW-1)-bit dividend over a DW-bit divisor, one quotient bit per cycle.
// Optional macro DIV_OVF_CHECK_EN flags quotients that do not fit in DW bits; without it q_ovf is tied to 0.
module seq_divider_8bit #(
  parameter int unsigned DW = 8
) (
  input logic                clk,
  input logic                rst_n,
  seq_divider_8bit_if.slave  bus
);
  localparam int unsigned NW = 2 * DW - 1;
  localparam int unsigned CW = $clog2(NW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state,     w_state_n;
  logic [CW-1:0] r_cnt,       w_cnt_n;
  logic [NW-1:0] r_q,         w_q_n;
  logic [DW-1:0] r_part,      w_part_n;
  logic [DW-1:0] r_dvs,       w_dvs_n;
  logic [NW-1:0] r_quotient,  w_quotient_n;
  logic [DW-1:0] r_remainder, w_remainder_n;
  logic          r_div_zero,  w_div_zero_n;
  logic          r_in_ready,  w_in_ready_n;
  logic          r_out_valid, w_out_valid_n;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder always stays below the divisor, so only its low DW bits are held.
  logic [DW:0]   w_t;
  logic          w_ge;
  logic [DW-1:0] w_diff;

  assign w_t    = {r_part, r_q[NW-1]};
  assign w_ge   = (w_t >= {1'b0, r_dvs});
  assign w_diff = DW'(w_t - {1'b0, r_dvs});

`ifdef DIV_OVF_CHECK_EN
  logic r_q_ovf, w_q_ovf_n;
`endif

  // Next-state and datapath update.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_q_n         = r_q;
    w_part_n      = r_part;
    w_dvs_n       = r_dvs;
    w_quotient_n  = r_quotient;
    w_remainder_n = r_remainder;
    w_div_zero_n  = r_div_zero;
`ifdef DIV_OVF_CHECK_EN
    w_q_ovf_n     = r_q_ovf;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor != '0) begin
            w_q_n     = bus.dividend;
            w_dvs_n   = bus.divisor;
            w_part_n  = '0;
            w_cnt_n   = CW'(NW - 1);
            w_state_n = S_CALC;
          end else begin
            w_quotient_n  = '1;
            w_remainder_n = bus.dividend[DW-1:0];
            w_div_zero_n  = 1'b1;
`ifdef DIV_OVF_CHECK_EN
            w_q_ovf_n     = 1'b1;
`endif
            w_state_n     = S_DONE;
          end
        end
      end

      S_CALC: begin
        w_q_n    = {r_q[NW-2:0], w_ge};
        w_part_n = w_ge ? w_diff : w_t[DW-1:0];
        if (r_cnt == '0) begin
          w_quotient_n  = w_q_n;
          w_remainder_n = w_part_n;
          w_div_zero_n  = 1'b0;
`ifdef DIV_OVF_CHECK_EN
          w_q_ovf_n     = |w_q_n[NW-1:DW];
`endif
          w_state_n     = S_DONE;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          w_state_n = S_IDLE;
        end
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Handshake flags are registered copies of the state being entered.
    w_in_ready_n  = (w_state_n == S_IDLE);
    w_out_valid_n = (w_state_n == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_q         <= '0;
      r_part      <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_q         <= w_q_n;
      r_part      <= w_part_n;
      r_dvs       <= w_dvs_n;
      r_quotient  <= w_quotient_n;
      r_remainder <= w_remainder_n;
      r_div_zero  <= w_div_zero_n;
      r_in_ready  <= w_in_ready_n;
      r_out_valid <= w_out_valid_n;
    end
  end

`ifdef DIV_OVF_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_ovf <= 1'b0;
    end else begin
      r_q_ovf <= w_q_ovf_n;
    end
  end

  assign bus.q_ovf = r_q_ovf;
`else
  assign bus.q_ovf = 1'b0;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.div_zero  = r_div_zero;
endmodule
